// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// halt word and the fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 8'h01;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_VALID = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_t;

  // True when a captured ROM word is the halt marker.
  function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: reset to RESET_PC, load on redirect, or step by
// one (wrapping at the address width). Load wins over increment.
module fetch_pc
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC update: reset, then redirect, then sequential increment.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (load)
      pc <= load_addr;
    else if (inc)
      pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one word per fetch from a ROM with a
// one-cycle registered read and hands it to the decoder via ir/ir_valid/ir_ready.
// Optional build macro FETCH_HALT_ON_ZERO_EN: a fetched 16'h0000 stops
// fetching (HALT) instead of being delivered.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FETCH_REQ   | rom_read asserted for address pc
// FETCH_WAIT  | ROM word arrives; captured into ir, pc advances
// FETCH_VALID | ir presented to decoder, held until accepted
// FETCH_HALT  | halt word seen; idle until redirect or reset
module instr_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               rom_read,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         pc_load;
  logic         pc_inc;
  logic         ir_load;

  fetch_pc u_fetch_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // State register and instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_REQ;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (ir_load)
        ir <= rom_data;
    end
  end

  // Next-state and datapath enables; a redirect overrides everything,
  // including a capture in WAIT, so the in-flight word is dropped.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;

    case (state)
      FETCH_REQ: begin
        state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        pc_inc = 1'b1;
`ifdef FETCH_HALT_ON_ZERO_EN
        if (is_halt_word(rom_data)) begin
          state_next = FETCH_HALT;
        end else begin
          ir_load    = 1'b1;
          state_next = FETCH_VALID;
        end
`else
        ir_load    = 1'b1;
        state_next = FETCH_VALID;
`endif
      end
      FETCH_VALID: begin
        if (ir_ready)
          state_next = FETCH_REQ;
      end
      FETCH_HALT: begin
        state_next = FETCH_HALT;
      end
      default: begin
        state_next = FETCH_REQ;
      end
    endcase

    if (jump_en) begin
      pc_load    = 1'b1;
      pc_inc     = 1'b0;
      ir_load    = 1'b0;
      state_next = FETCH_REQ;
    end
  end

  assign rom_read = (state == FETCH_REQ);
  assign rom_addr = pc;
  assign ir_valid = (state == FETCH_VALID);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted = (state == FETCH_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by randomized
// redirect/reset/ready traffic, checked against a transaction-level model
// and a scoreboard of delivered instructions.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        rom_read;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  pc;
  logic        halted;

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .rom_read  (rom_read),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    case (a)
      8'h01:   return 16'hC041;
      8'h02:   return 16'hC082;
      8'h03:   return 16'h2081;
      8'h05:   return 16'h1042;
      default: return 16'h0000;
    endcase
  endfunction

  // Program ROM: one-cycle registered read.
  always @(posedge clk) if (rom_read) rom_data <= rom_word(rom_addr);

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;
  logic [15:0] exp_q[$];

  // Reference model. phase: 0 = issuing read, 1 = word arriving,
  // 2 = word offered to decoder, 3 = halted.
  int          m_phase = 0;
  logic [7:0]  m_pc    = 8'h01;
  logic [15:0] m_ir    = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic j, input logic [7:0] ja, input logic rdy);
    logic [15:0] w;
    if (r) begin
      m_phase = 0; m_pc = 8'h01; m_ir = 16'h0000;
    end else if (j) begin
      m_phase = 0; m_pc = ja;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          w    = rom_word(m_pc);
          m_pc = m_pc + 8'd1;
`ifdef FETCH_HALT_ON_ZERO_EN
          if (w == 16'h0000) m_phase = 3;
          else begin m_ir = w; m_phase = 2; end
`else
          m_ir = w; m_phase = 2;
`endif
        end
        2: if (rdy) m_phase = 0;
        default: m_phase = m_phase;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic j, input logic [7:0] ja, input logic rdy);
    rst = r; jump_en = j; jump_addr = ja; ir_ready = rdy;
    if (m_phase == 2 && rdy) exp_q.push_back(m_ir);
    @(posedge clk);
    model_edge(r, j, ja, rdy);
    #1;
  endtask

  task automatic at_negedge();
    @(negedge clk);
  endtask

  // Monitor: per-cycle output checks and scoreboard pops on each transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rom_read", rom_read, (m_phase == 0));
      chk("rom_addr", rom_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("ir_valid", ir_valid, (m_phase == 2));
      chk("halted", halted, (m_phase == 3));
      chk("ir", ir, m_ir);
      if (ir_valid === 1'b1 && ir_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_delivery", {16'h0, ir}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_delivery", ir, exp_q.pop_front());
        end
      end
    end
  end

  logic [7:0] targets [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0A, 8'hFF};

  initial begin
    rst = 1'b1; jump_en = 1'b0; jump_addr = 8'h00; ir_ready = 1'b0;

    // Reset, release with ir_ready=1.
    step(1, 0, 8'h00, 1);
    mon_en = 1;
    at_negedge();
    chk("s1_rom_read", rom_read, 1);
    chk("s1_rom_addr", rom_addr, 8'h01);
    chk("s1_ir_valid", ir_valid, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    at_negedge();
    chk("s1_ir", ir, 16'hC041);
    chk("s1_valid", ir_valid, 1);
    chk("s1_pc", pc, 8'h02);

    // Stall in VALID for 5 cycles, then accept.
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'h00, 0);
      at_negedge();
      chk("s2_hold_ir", ir, 16'hC041);
      chk("s2_no_read", rom_read, 0);
    end
    step(0, 0, 8'h00, 1);
    at_negedge();
    chk("s2_next_addr", rom_addr, 8'h02);
    chk("s2_next_read", rom_read, 1);

    // Redirect during WAIT of the fetch at 02.
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h05, 1);
    at_negedge();
    chk("s3_drop_valid", ir_valid, 0);
    chk("s3_addr", rom_addr, 8'h05);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    at_negedge();
    chk("s3_ir", ir, 16'h1042);
    chk("s3_pc", pc, 8'h06);

    // Fetch of a zero word at 0A.
    step(0, 1, 8'h0A, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    at_negedge();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("s4_halted", halted, 1);
    chk("s4_pc", pc, 8'h0B);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h00, 1);
      at_negedge();
      chk("s4_no_read", rom_read, 0);
    end
    step(0, 1, 8'h01, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    at_negedge();
    chk("s4_resume_ir", ir, 16'hC041);
`else
    chk("s4_zero_ir", ir, 16'h0000);
    chk("s4_zero_valid", ir_valid, 1);
    chk("s4_not_halted", halted, 0);
`endif

    // Wrap of pc past 8'hFF.
    step(0, 1, 8'hFF, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    at_negedge();
    chk("s5_pc_wrap", pc, 8'h00);
    step(0, 0, 8'h00, 1);
    at_negedge();
    chk("s5_next_addr", rom_addr, 8'h00);

    // Reset in WAIT, then reset in VALID.
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h05, 0);
    at_negedge();
    chk("s6w_valid", ir_valid, 0);
    chk("s6w_pc", pc, 8'h01);
    chk("s6w_ir", ir, 16'h0000);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    at_negedge();
    chk("s6w_restart_ir", ir, 16'hC041);
    step(1, 0, 8'h00, 1);
    at_negedge();
    chk("s6v_valid", ir_valid, 0);
    chk("s6v_pc", pc, 8'h01);
    chk("s6v_addr", rom_addr, 8'h01);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic r, j, rdy;
      logic [7:0] ja;
      r   = ($urandom_range(0, 59) == 0);
      j   = ($urandom_range(0, 11) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : targets[$urandom_range(0, 7)];
      rdy = 1'($urandom_range(0, 1));
      step(r, j, ja, rdy);
    end

    step(0, 0, 8'h00, 0);
    at_negedge();
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
